// File: rtl/step_detector.sv
// -----------------------------------------------------------------------------
// step_detector
//
// Purpose:
//   Turns the node stage's filtered activity samples into pedometer steps.
//   A sample at or above HI_TH counts one step and enters the high phase.
//   The high phase ends on a sample at or below LO_TH. REFRACT further valid
//   samples are then ignored before the detector re-arms. Steps are counted
//   in a saturating counter, and a sticky flag records any step lost to
//   saturation.
//
// Ports:
//   clk          in   rising-edge clock shared with the node stage
//   rst_n        in   asynchronous active-low reset
//   sample_in    in   [DW-1:0] unsigned activity sample
//   sample_valid in   sample_in is new this cycle and is consumed on this edge
//   clear        in   synchronous clear of count, flags and FSM; beats a
//                     coincident valid sample
//   step_pulse   out  one-cycle strobe per detected step
//   step_count   out  [CW-1:0] saturating step count
//   sat          out  sticky: a step arrived while step_count was all-ones
//   state        out  [1:0] FSM state for debug: LOW=0, HIGH=1, REFR=2
//   peak_val     out  [DW-1:0] largest sample of the current/last high phase
//                     (present only when STEP_DET_PEAK_EN is defined)
//
// Configuration macro:
//   STEP_DET_PEAK_EN - adds the peak_val output and its register.
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module step_detector #(
    parameter int            DW      = 8,
    parameter int            CW      = 16,
    parameter logic [DW-1:0] HI_TH   = DW'(96),
    parameter logic [DW-1:0] LO_TH   = DW'(64),
    parameter int            REFRACT = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_valid,
    input  logic          clear,
    output logic          step_pulse,
    output logic [CW-1:0] step_count,
    output logic          sat,
    output logic [1:0]    state
`ifdef STEP_DET_PEAK_EN
    ,
    output logic [DW-1:0] peak_val
`endif
);

    localparam logic [1:0] ST_LOW  = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_REFR = 2'd2;

    // The refractory counter counts down to zero. It is loaded with
    // REFRACT-1, so REFR lasts exactly REFRACT valid samples.
    localparam logic [7:0] REFR_LOAD = (REFRACT > 0) ? 8'(REFRACT - 1) : 8'd0;

    logic [1:0]    state_q, state_d;
    logic [7:0]    refr_cnt_q, refr_cnt_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] count_q, count_d;
    logic          sat_q, sat_d;
`ifdef STEP_DET_PEAK_EN
    logic [DW-1:0] peak_q, peak_d;
`endif

    // NOTE: every next-state signal is given its hold value first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        refr_cnt_d = refr_cnt_q;
        pulse_d    = 1'b0;
        count_d    = count_q;
        sat_d      = sat_q;
`ifdef STEP_DET_PEAK_EN
        peak_d     = peak_q;
`endif

        if (clear) begin
            // Clear wins over a coincident valid sample; that sample is dropped.
            state_d    = ST_LOW;
            refr_cnt_d = 8'd0;
            count_d    = '0;
            sat_d      = 1'b0;
`ifdef STEP_DET_PEAK_EN
            peak_d     = '0;
`endif
        end else if (sample_valid) begin
            case (state_q)
                ST_LOW: begin
                    if (sample_in >= HI_TH) begin
                        state_d = ST_HIGH;
                        pulse_d = 1'b1;
                        // At all-ones the step is still reported, but it is
                        // recorded only in the sticky flag.
                        if (count_q == {CW{1'b1}}) begin
                            sat_d = 1'b1;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
`ifdef STEP_DET_PEAK_EN
                        peak_d = sample_in;
`endif
                    end
                end

                ST_HIGH: begin
`ifdef STEP_DET_PEAK_EN
                    if (sample_in > peak_q) begin
                        peak_d = sample_in;
                    end
`endif
                    if (sample_in <= LO_TH) begin
                        if (REFRACT > 0) begin
                            state_d    = ST_REFR;
                            refr_cnt_d = REFR_LOAD;
                        end else begin
                            state_d = ST_LOW;
                        end
                    end
                end

                ST_REFR: begin
                    // Sample value is irrelevant here; only the count matters.
                    if (refr_cnt_q == 8'd0) begin
                        state_d = ST_LOW;
                    end else begin
                        refr_cnt_d = refr_cnt_q - 8'd1;
                    end
                end

                default: begin
                    state_d    = ST_LOW;
                    refr_cnt_d = 8'd0;
                end
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments, so every flop
    // samples pre-edge values and simulation matches the synthesized registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOW;
            refr_cnt_q <= 8'd0;
            pulse_q    <= 1'b0;
            count_q    <= '0;
            sat_q      <= 1'b0;
`ifdef STEP_DET_PEAK_EN
            peak_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            refr_cnt_q <= refr_cnt_d;
            pulse_q    <= pulse_d;
            count_q    <= count_d;
            sat_q      <= sat_d;
`ifdef STEP_DET_PEAK_EN
            peak_q     <= peak_d;
`endif
        end
    end

    assign step_pulse = pulse_q;
    assign step_count = count_q;
    assign sat        = sat_q;
    assign state      = state_q;
`ifdef STEP_DET_PEAK_EN
    assign peak_val   = peak_q;
`endif

endmodule

// File: doc/step_detector.md
# step_detector

Downstream consumer of the node stage's registered 8-bit `nodeResult`. It treats each valid node output as one filtered activity sample and finds steps with a hysteresis threshold pair plus a refractory window. It keeps a saturating step count for the pedometer core. The block is fully synchronous to the node's clock, and all outputs are registered.

## Interface
Parameters:
- `DW`, 8: sample width; matches node output width.
- `CW`, 16: step counter width.
- `HI_TH`, 8'd96: rising threshold (unsigned). A sample `>= HI_TH` arms a step.
- `LO_TH`, 8'd64: falling threshold (unsigned). A sample `<= LO_TH` ends the high phase. `HI_TH > LO_TH` is required; the bench checks this at elaboration.
- `REFRACT`, 10: number of valid samples ignored after each high phase; range 0..255.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `sample_in`, input, DW: unsigned sample from the node stage.
- `sample_valid`, input, 1: `sample_in` is new this cycle; the sample is consumed on this edge.
- `clear`, input, 1: synchronous clear of count, flags and FSM.
- `step_pulse`, output, 1: one-cycle strobe per detected step.
- `step_count`, output, CW: number of steps detected; saturating.
- `sat`, output, 1: sticky flag, set when a step occurs while `step_count` is already all-ones.
- `state`, output, 2: FSM state for debug. LOW=0, HIGH=1, REFR=2.
- `peak_val`, output, DW: present only with `STEP_DET_PEAK_EN` (see Configuration).

## Operation
- **Reset** (`rst_n`=0, asynchronous):
  - state=LOW, refractory counter=0.
  - `step_pulse`=0, `step_count`=0, `sat`=0, `peak_val`=0.
- **FSM.** Transitions are evaluated only on edges with `sample_valid`=1.
  - LOW: if `sample_in >= HI_TH`, go to HIGH, assert `step_pulse`, and increment `step_count`. Otherwise stay in LOW.
  - HIGH: if `sample_in <= LO_TH`, then:
    - with REFRACT>0, go to REFR and load the counter with REFRACT-1;
    - with REFRACT=0, go directly to LOW.
    - Otherwise stay in HIGH, and no further step is counted.
  - REFR: every valid sample is ignored, including values above `HI_TH`. If the counter is 0, go to LOW; otherwise decrement it. The block therefore ignores exactly REFRACT samples.
- **Idle cycles.** `sample_valid`=0 means no state change and no counter change, and `step_pulse`=0.
- **Saturation.** A step with `step_count` = 2^CW−1 leaves the count unchanged. It still asserts `step_pulse` and sets `sat`. `sat` clears only on `clear` or reset.
- **Clear.**
  - Sets state=LOW, counter=0, `step_count`=0, `sat`=0, `peak_val`=0, and `step_pulse`=0 on that edge.
  - `clear` has priority over a coincident valid sample; that sample is dropped.
- **Comparisons.** All comparisons are unsigned, full DW width, with no arithmetic on the sample.

## Timing
- Latency: a crossing sample presented at edge N produces `step_pulse`=1 and the updated `step_count` after edge N. They are visible during cycle N+1.
- `step_pulse` is high for exactly one cycle per step, even with back-to-back valid samples.
- Throughput: one sample per cycle. There is no backpressure, and the upstream node may assert valid every cycle.
- Minimum spacing between two pulses, counted in valid samples, is 2+REFRACT: the crossing sample, the falling sample, then REFRACT ignored samples.
- Reset mid-phase (HIGH or REFR) returns to LOW immediately, without waiting for a clock. The first valid sample after `rst_n` rises is evaluated from LOW.

## Configuration
- Macro: `STEP_DET_PEAK_EN`.
- Defined:
  - The `peak_val` output and register exist.
  - On the LOW→HIGH edge, `peak_val` loads the crossing sample.
  - While in HIGH, each valid sample updates `peak_val` to max(`peak_val`, `sample_in`).
  - `peak_val` holds in LOW and REFR, and resets or clears to 0.
- Undefined: the `peak_val` port and its logic are absent. All other behaviour is identical.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-HIGH → `state`=0, `step_count`=0, `step_pulse`=0, `sat`=0 immediately, without a clock edge.
- **Single step:** with defaults, feed valid samples 50, 100, 120, 60, then 10 samples of 0, then 100 → exactly 2 pulses.
  - The first pulse follows the sample 100; `step_count` then reads 1, then 2.
  - With the macro, `peak_val`=120 after the first high phase.
- **Refractory:** REFRACT=3, feed 100, 60, 200, 200, 200, 100 → pulses only after the first 100 and the last 100; `step_count`=2.
- **Hysteresis:** feed 100, 80, 97, 70, 99 → 1 pulse, since the signal never reaches ≤64 between the highs.
- **Saturation and clear:**
  - CW=4, 17 steps → `step_count`=15 and `sat`=1; all 17 pulses are seen.
  - `clear` together with a valid 200 sample → count=0, `sat`=0, no pulse.
- **Valid gaps:** interleave `sample_valid`=0 cycles carrying 255 on `sample_in` → no pulses and no state change on those cycles.
